// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state type for the CPU memory-port master bridge.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } mbr_state_e;

    // AxSIZE encoding (log2 of bytes per beat); nbytes must be a power of two.
    function automatic logic [2:0] axi_size(input int unsigned nbytes);
        logic [2:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == nbytes) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/mbr_rd_line_buf.sv
// Read line buffer: beat counter plus RD_BEATS x DATA_W line register for bursts.
module mbr_rd_line_buf #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_BEATS = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         we_i,
    input  logic                         last_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W*RD_BEATS-1:0]   line_o,
    output logic                         last_o
);

    localparam int unsigned CNT_W = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DATA_W*RD_BEATS-1:0]   line_q, line_d;

    assign last_o = (cnt_q == CNT_W'(RD_BEATS - 1));
    assign line_o = line_q;

    // Early RLAST ends the burst too; slots beyond it keep their previous contents.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (we_i) begin
            for (int unsigned k = 0; k < RD_BEATS; k++) begin
                if (cnt_q == CNT_W'(k)) line_d[k*DATA_W +: DATA_W] = wdata_i;
            end
            cnt_d = (last_i || last_o) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/axi_mem_master_bridge.sv
// CPU SRAM-style port to AXI4 master bridge; write-then-read serialisation under one stall.
// Optional sticky response-error output enabled by defining MBR_RESP_ERR_EN.
module axi_mem_master_bridge
    import axi_pkg::*;
#(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_BEATS = 1,
    parameter int unsigned MST_ID   = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       req_rd,
    input  logic                       req_wr,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W-1:0]          req_bweb,
    output logic [DATA_W*RD_BEATS-1:0] rdata,
    output logic                       stall,
`ifdef MBR_RESP_ERR_EN
    output logic                       resp_err,
`endif
    output logic [ID_W-1:0]            AWID,
    output logic [ADDR_W-1:0]          AWADDR,
    output logic [7:0]                 AWLEN,
    output logic [2:0]                 AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [DATA_W-1:0]          WDATA,
    output logic [DATA_W/8-1:0]        WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [ID_W-1:0]            BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY,
    output logic [ID_W-1:0]            ARID,
    output logic [ADDR_W-1:0]          ARADDR,
    output logic [7:0]                 ARLEN,
    output logic [2:0]                 ARSIZE,
    output logic [1:0]                 ARBURST,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [ID_W-1:0]            RID,
    input  logic [DATA_W-1:0]          RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RLAST,
    input  logic                       RVALID,
    output logic                       RREADY
);

    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned LINE_BYTES = DATA_W * RD_BEATS / 8;

    mbr_state_e            state_q, state_d;
    logic                  pend_wr_q, pend_wr_d;
    logic                  pend_rd_q, pend_rd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [STRB_W-1:0]     req_strb;

    logic                  rd_we, rd_end, rd_last;

    always_comb begin
        req_strb = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            req_strb[i] = ~&req_bweb[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                pend_wr_d = req_wr;
                pend_rd_d = req_rd;
                addr_d    = req_addr;
                wdata_d   = req_wdata;
                wstrb_d   = req_strb;
                if (req_wr)      state_d = ST_AW;
                else if (req_rd) state_d = ST_AR;
            end
            ST_AW: if (AWREADY) state_d = ST_W;
            ST_W:  if (WREADY)  state_d = ST_B;
            ST_B: begin
                if (BVALID) begin
                    pend_wr_d = 1'b0;
                    state_d   = pend_rd_q ? ST_AR : ST_DONE;
                end
            end
            ST_AR: if (ARREADY) state_d = ST_R;
            ST_R: begin
                if (rd_end) begin
                    pend_rd_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign stall = (req_rd | req_wr) && (state_q != ST_DONE);

    assign AWID    = ID_W'(MST_ID);
    assign AWADDR  = addr_q;
    assign AWLEN   = '0;
    assign AWSIZE  = axi_size(STRB_W);
    assign AWBURST = BURST_INCR;
    assign AWVALID = (state_q == ST_AW);

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = (state_q == ST_W);

    assign BREADY  = (state_q == ST_B);

    // Line fills start on a line boundary so the burst covers the whole line.
    assign ARID    = ID_W'(MST_ID);
    assign ARADDR  = addr_q - (addr_q % ADDR_W'(LINE_BYTES));
    assign ARLEN   = 8'(RD_BEATS - 1);
    assign ARSIZE  = axi_size(STRB_W);
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state_q == ST_AR);

    assign RREADY  = (state_q == ST_R);

    assign rd_we  = (state_q == ST_R) && RVALID;
    assign rd_end = rd_we && (RLAST || rd_last);

    mbr_rd_line_buf #(
        .DATA_W   (DATA_W),
        .RD_BEATS (RD_BEATS)
    ) u_line_buf (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .clr_i   (state_q == ST_AR),
        .we_i    (rd_we),
        .last_i  (RLAST),
        .wdata_i (RDATA),
        .line_o  (rdata),
        .last_o  (rd_last)
    );

    logic unused_ids;
    assign unused_ids = ^{BID, RID};

`ifdef MBR_RESP_ERR_EN
    logic resp_err_q, resp_err_d;

    always_comb begin
        resp_err_d = resp_err_q;
        if (BVALID && BREADY && (BRESP != RESP_OKAY)) resp_err_d = 1'b1;
        if (RVALID && RREADY && (RRESP != RESP_OKAY)) resp_err_d = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) resp_err_q <= 1'b0;
        else          resp_err_q <= resp_err_d;
    end

    assign resp_err = resp_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{BRESP, RRESP};
`endif

endmodule

// File: tb/tb_axi_mem_master_bridge.sv
// Directed bench: single-beat bridge (dut1) and 4-beat line-fill bridge (dut4), shared slave inputs.
module tb_axi_mem_master_bridge;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    logic        a_req_rd, a_req_wr, b_req_rd, b_req_wr;
    logic [31:0] req_addr, req_wdata, req_bweb;

    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
    logic [1:0]  BRESP, RRESP;
    logic [3:0]  BID, RID;
    logic [31:0] RDATA;

    logic [31:0]  a_rdata;
    logic [127:0] b_rdata;
    logic a_stall, b_stall;
    logic [3:0]  a_AWID, b_AWID, a_ARID, b_ARID, a_WSTRB, b_WSTRB;
    logic [31:0] a_AWADDR, b_AWADDR, a_ARADDR, b_ARADDR, a_WDATA, b_WDATA;
    logic [7:0]  a_AWLEN, b_AWLEN, a_ARLEN, b_ARLEN;
    logic [2:0]  a_AWSIZE, b_AWSIZE, a_ARSIZE, b_ARSIZE;
    logic [1:0]  a_AWBURST, b_AWBURST, a_ARBURST, b_ARBURST;
    logic a_AWVALID, b_AWVALID, a_WLAST, b_WLAST, a_WVALID, b_WVALID;
    logic a_BREADY, b_BREADY, a_ARVALID, b_ARVALID, a_RREADY, b_RREADY;
`ifdef MBR_RESP_ERR_EN
    logic a_resp_err, b_resp_err;
`endif

    axi_mem_master_bridge #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .RD_BEATS(1), .MST_ID(0)) dut1 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_rd(a_req_rd), .req_wr(a_req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_bweb(req_bweb), .rdata(a_rdata), .stall(a_stall),
`ifdef MBR_RESP_ERR_EN
        .resp_err(a_resp_err),
`endif
        .AWID(a_AWID), .AWADDR(a_AWADDR), .AWLEN(a_AWLEN), .AWSIZE(a_AWSIZE),
        .AWBURST(a_AWBURST), .AWVALID(a_AWVALID), .AWREADY(AWREADY),
        .WDATA(a_WDATA), .WSTRB(a_WSTRB), .WLAST(a_WLAST), .WVALID(a_WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(a_BREADY),
        .ARID(a_ARID), .ARADDR(a_ARADDR), .ARLEN(a_ARLEN), .ARSIZE(a_ARSIZE),
        .ARBURST(a_ARBURST), .ARVALID(a_ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(a_RREADY)
    );

    axi_mem_master_bridge #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .RD_BEATS(4), .MST_ID(3)) dut4 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_rd(b_req_rd), .req_wr(b_req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_bweb(req_bweb), .rdata(b_rdata), .stall(b_stall),
`ifdef MBR_RESP_ERR_EN
        .resp_err(b_resp_err),
`endif
        .AWID(b_AWID), .AWADDR(b_AWADDR), .AWLEN(b_AWLEN), .AWSIZE(b_AWSIZE),
        .AWBURST(b_AWBURST), .AWVALID(b_AWVALID), .AWREADY(AWREADY),
        .WDATA(b_WDATA), .WSTRB(b_WSTRB), .WLAST(b_WLAST), .WVALID(b_WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(b_BREADY),
        .ARID(b_ARID), .ARADDR(b_ARADDR), .ARLEN(b_ARLEN), .ARSIZE(b_ARSIZE),
        .ARBURST(b_ARBURST), .ARVALID(b_ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(b_RREADY)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic slave_idle();
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
    endtask

    initial begin
        BID = 4'h5; RID = 4'h6;
        slave_idle();
        a_req_wr = 0; b_req_rd = 0; b_req_wr = 0;
        req_wdata = '0; req_bweb = '1;

        // Reset with a pending read on dut1; slave is zero-wait for its read.
        ARESETn = 0; a_req_rd = 1; req_addr = 32'h0000_0010;
        ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RLAST = 1;
        tick(); tick();
        check("rst_stall", a_stall, 1'b1);
        check("rst_arvalid", a_ARVALID, 1'b0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_b_valids", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID, b_RREADY}, 5'b0);
`ifdef MBR_RESP_ERR_EN
        check("rst_resp_err", b_resp_err, 1'b0);
`endif

        // Zero-wait single-beat read: ARVALID in cycle 1, stall low in cycle 3.
        ARESETn = 1;
        tick();
        check("t1_arvalid", a_ARVALID, 1'b1);
        check("t1_araddr", a_ARADDR, 32'h0000_0010);
        check("t1_arlen", a_ARLEN, 8'd0);
        check("t1_arsize_burst", {a_ARSIZE, a_ARBURST}, {3'd2, 2'b01});
        check("t1_stall_c1", a_stall, 1'b1);
        tick();
        check("t1_rready", a_RREADY, 1'b1);
        check("t1_stall_c2", a_stall, 1'b1);
        tick();
        check("t1_stall_c3", a_stall, 1'b0);
        check("t1_rdata", a_rdata, 32'hDEAD_BEEF);
        a_req_rd = 0;
        tick();
        check("t1_idle", {a_stall, a_ARVALID}, 2'b00);

        // 4-beat line fill with 2-cycle RVALID gaps.
        slave_idle();
        ARREADY = 1; req_addr = 32'h0001_0024; b_req_rd = 1;
        tick();
        check("t2_arvalid", b_ARVALID, 1'b1);
        check("t2_araddr", b_ARADDR, 32'h0001_0020);
        check("t2_arlen", b_ARLEN, 8'd3);
        check("t2_arid", b_ARID, 4'd3);
        tick();
        ARREADY = 0;
        for (int k = 0; k < 4; k++) begin
            RVALID = 0;
            tick(); tick();
            check("t2_stall_gap", b_stall, 1'b1);
            RVALID = 1; RDATA = 32'(32'h1111_1111 * (k + 1)); RLAST = (k == 3);
            check("t2_rready", b_RREADY, 1'b1);
            tick();
        end
        slave_idle();
        check("t2_stall_done", b_stall, 1'b0);
        check("t2_rdata", b_rdata, 128'h44444444_33333333_22222222_11111111);
        b_req_rd = 0;
        tick();

        // Write with AWREADY held low for 5 cycles.
        req_addr = 32'h0000_0040; req_wdata = 32'h1234_5678; req_bweb = 32'hFFFF_00FF;
        b_req_wr = 1;
        tick();
        check("t3_aw_attr", {b_AWLEN, b_AWSIZE, b_AWBURST, b_AWID}, {8'd0, 3'd2, 2'b01, 4'd3});
        for (int i = 0; i < 5; i++) begin
            check("t3_awvalid_hold", {b_AWVALID, b_AWADDR}, {1'b1, 32'h0000_0040});
            tick();
        end
        AWREADY = 1;
        check("t3_awvalid_last", b_AWVALID, 1'b1);
        tick();
        AWREADY = 0;
        check("t3_w_phase", {b_AWVALID, b_WVALID, b_WLAST}, 3'b011);
        check("t3_wstrb", b_WSTRB, 4'b0010);
        check("t3_wdata", b_WDATA, 32'h1234_5678);
        WREADY = 1;
        tick();
        WREADY = 0;
        check("t3_bready", {b_WVALID, b_BREADY, b_stall}, 3'b011);
        BVALID = 1;
        tick();
        check("t3_stall_done", b_stall, 1'b0);
        BVALID = 0; b_req_wr = 0;
        tick();

        // Write and read together, zero-wait slave: write fully precedes AR.
        AWREADY = 1; WREADY = 1; BVALID = 1; ARREADY = 1; RVALID = 1; RLAST = 0;
        req_addr = 32'h0000_0080; req_wdata = 32'hCAFE_F00D; req_bweb = 32'h0;
        b_req_rd = 1; b_req_wr = 1;
        tick();
        check("t4_c1", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID}, 4'b1000);
        tick();
        check("t4_c2", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID, b_WSTRB}, 8'b0100_1111);
        tick();
        check("t4_c3", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID}, 4'b0010);
        tick();
        check("t4_c4", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID}, 4'b0001);
        check("t4_araddr", b_ARADDR, 32'h0000_0080);
        tick();
        for (int k = 0; k < 4; k++) begin
            RDATA = 32'h0000_0100 + 32'(k);
            check("t4_stall_r", {b_stall, b_RREADY}, 2'b11);
            tick();
        end
        check("t4_stall_done", b_stall, 1'b0);
        check("t4_rdata", b_rdata, 128'h00000103_00000102_00000101_00000100);
        b_req_rd = 0; b_req_wr = 0;
        slave_idle();
        tick();
        check("t4_idle", {b_stall, b_AWVALID, b_ARVALID}, 3'b000);

        // Reset during R after one of four beats.
        ARREADY = 1; req_addr = 32'h0000_0100; b_req_rd = 1;
        tick(); tick();
        ARREADY = 0;
        RVALID = 1; RDATA = 32'hCAFE_0000;
        tick();
        RVALID = 0; ARESETn = 0;
        tick();
        check("t5_valids", {b_AWVALID, b_WVALID, b_BREADY, b_ARVALID, b_RREADY}, 5'b0);
        check("t5_rdata", b_rdata, 128'h0);
        check("t5_stall", b_stall, 1'b1);
        ARESETn = 1; b_req_rd = 0;
        tick();

        // Early RLAST after 2 beats: upper slots keep reset contents.
        ARREADY = 1; req_addr = 32'h0000_0008; b_req_rd = 1;
        tick();
        check("t6_araddr", b_ARADDR, 32'h0000_0000);
        tick();
        ARREADY = 0;
        RVALID = 1; RDATA = 32'hAAAA_0001; RLAST = 0;
        tick();
        RDATA = 32'hAAAA_0002; RLAST = 1;
        tick();
        check("t6_stall_done", b_stall, 1'b0);
        check("t6_rdata", b_rdata, 128'h00000000_00000000_AAAA0002_AAAA0001);
        slave_idle(); b_req_rd = 0;
        tick();

`ifdef MBR_RESP_ERR_EN
        // SLVERR on B sets the sticky flag; a later OKAY read leaves it set.
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10; b_req_wr = 1;
        tick(); tick(); tick(); tick();
        check("t7_stall_done", b_stall, 1'b0);
        check("t7_resp_err_set", b_resp_err, 1'b1);
        b_req_wr = 0;
        slave_idle();
        tick();
        ARREADY = 1; RVALID = 1; RLAST = 1; RDATA = 32'h0BAD_F00D; b_req_rd = 1;
        tick(); tick(); tick();
        check("t7_read_done", b_stall, 1'b0);
        check("t7_resp_err_sticky", b_resp_err, 1'b1);
        check("t7_a_resp_err", a_resp_err, 1'b0);
        b_req_rd = 0;
        slave_idle();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
